// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice allocator for a NUM_VOICES-voice synthesizer.
// An accepted note event is resolved by a serial scan of the voices, one per cycle.
// The outcome takes effect in a single commit cycle, NUM_VOICES+1 cycles after accept.
//
// Ports:
//   clk_in, rst_in         clock, asynchronous active-low reset
//   note_valid_in/ready    event handshake; ready is high only while idle
//   note_on_in/key/incr    event fields (on/off, 7-bit key, phase increment)
//   phase_incr_out         per-voice increment; voice i sits at [i*PHASE_W +: PHASE_W]
//   gate_out               per-voice active flag
//   alloc_valid_out/voice  one-cycle pulse and voice index for a committed event
//   drop_out               one-cycle pulse for a discarded event
//
// Optional feature: define VOICE_STEAL_EN to steal the oldest (LRU) voice for a
// note-on when no voice is free or already playing the key. Otherwise that note-on
// is dropped.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 32
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            note_valid_in,
  output logic                            note_ready_out,
  input  logic                            note_on_in,
  input  logic [6:0]                      note_key_in,
  input  logic [PHASE_W-1:0]              note_incr_in,
  output logic [NUM_VOICES*PHASE_W-1:0]   phase_incr_out,
  output logic [NUM_VOICES-1:0]           gate_out,
  output logic                            alloc_valid_out,
  output logic [$clog2(NUM_VOICES)-1:0]   alloc_voice_out,
  output logic                            drop_out
);

  localparam int IW = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t               state;
  logic [IW-1:0]        scan_idx;

  // Latched event
  logic                 ev_on;
  logic [6:0]           ev_key;
  logic [PHASE_W-1:0]   ev_incr;

  // Scan results, collected one voice per cycle
  logic                 match_found;
  logic [IW-1:0]        match_idx;
  logic                 free_found;
  logic [IW-1:0]        free_idx;
`ifdef VOICE_STEAL_EN
  logic [IW-1:0]        old_idx;
`endif

  // Per-voice state
  logic [6:0]           key  [NUM_VOICES];
  logic [PHASE_W-1:0]   incr [NUM_VOICES];
  logic [IW-1:0]        age  [NUM_VOICES];

  // Commit decision
  logic                 hit;
  logic [IW-1:0]        voice;
  logic [IW-1:0]        voice_age;

  // Ready is held low for as long as reset is asserted, and goes high
  // immediately on release because the state is already IDLE.
  assign note_ready_out = rst_in && (state == IDLE);

  always_comb begin
    hit   = 1'b0;
    voice = '0;
    if (ev_on) begin
      if (match_found) begin
        hit   = 1'b1;
        voice = match_idx;
      end else if (free_found) begin
        hit   = 1'b1;
        voice = free_idx;
      end
`ifdef VOICE_STEAL_EN
      else begin
        hit   = 1'b1;
        voice = old_idx;
      end
`endif
    end else if (match_found) begin
      hit   = 1'b1;
      voice = match_idx;
    end
  end

  assign voice_age = age[voice];

  always_comb begin
    phase_incr_out = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      phase_incr_out[i*PHASE_W +: PHASE_W] = incr[i];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= IDLE;
      scan_idx        <= '0;
      ev_on           <= 1'b0;
      ev_key          <= '0;
      ev_incr         <= '0;
      match_found     <= 1'b0;
      match_idx       <= '0;
      free_found      <= 1'b0;
      free_idx        <= '0;
`ifdef VOICE_STEAL_EN
      old_idx         <= '0;
`endif
      gate_out        <= '0;
      alloc_valid_out <= 1'b0;
      alloc_voice_out <= '0;
      drop_out        <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        key[i]  <= '0;
        incr[i] <= '0;
        age[i]  <= IW'(i);
      end
    end else begin
      alloc_valid_out <= 1'b0;
      drop_out        <= 1'b0;
      case (state)
        IDLE: begin
          if (note_valid_in) begin
            ev_on       <= note_on_in;
            ev_key      <= note_key_in;
            ev_incr     <= note_incr_in;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          // First hit wins, giving lowest-index priority for both searches.
          if (gate_out[scan_idx] && (key[scan_idx] == ev_key) && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!gate_out[scan_idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
`ifdef VOICE_STEAL_EN
          // Ages are a permutation, so exactly one voice holds the oldest age.
          if (age[scan_idx] == IW'(NUM_VOICES - 1)) begin
            old_idx <= scan_idx;
          end
`endif
          if (scan_idx == IW'(NUM_VOICES - 1)) begin
            state <= COMMIT;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (!hit) begin
            drop_out <= 1'b1;
          end else begin
            alloc_valid_out <= 1'b1;
            alloc_voice_out <= voice;
            if (ev_on) begin
              gate_out[voice] <= 1'b1;
              key[voice]      <= ev_key;
              incr[voice]     <= ev_incr;
              // Move the chosen voice to the front of the LRU order. Only voices
              // newer than it shift back, so ages stay a permutation.
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (IW'(i) == voice) begin
                  age[i] <= '0;
                end else if (age[i] < voice_age) begin
                  age[i] <= age[i] + 1'b1;
                end
              end
            end else begin
              gate_out[voice] <= 1'b0;
              incr[voice]     <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
